// File: rtl/decoder_2x4_pulse.sv
// rtl/decoder_2x4_pulse.sv - registered 2-to-4 decoder turning encoded codes into timed one-hot strobes
module decoder_2x4_pulse #(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic v,
    input  logic y1,
    input  logic y0,
    output logic ready,
    output logic out3,
    output logic out2,
    output logic out1,
    output logic out0,
    output logic busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    // Counter runs PULSE_LEN-1 down to 0, so the strobe spans exactly PULSE_LEN cycles.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             pend_valid;
    logic [1:0]       pend_code;
    logic [1:0]       active_code;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             load;
    logic             accept;

    // A pending entry blocks new codes, so accept and consume never coincide.
    assign ready    = !pend_valid;
    assign accept   = v && ready;
    assign cnt_zero = (cnt == '0);

    // The pending code moves into the active register when idle or when the current strobe expires.
    assign load = pend_valid && ((state == IDLE) || cnt_zero);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a pending code at the last pulse cycle keeps us in PULSE with no gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (cnt_zero && !pend_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending buffer, active code and pulse counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_code   <= 2'b00;
            active_code <= 2'b00;
            cnt         <= '0;
        end else begin
            if (accept) begin
                pend_valid <= 1'b1;
                pend_code  <= {y1, y0};
            end else if (load) begin
                pend_valid <= 1'b0;
            end

            if (load) begin
                active_code <= pend_code;
                cnt         <= CNT_RELOAD;
            end else if ((state == PULSE) && !cnt_zero) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Strobes decode purely from registered state, so at most one line is ever high.
    always_comb begin
        out0 = 1'b0;
        out1 = 1'b0;
        out2 = 1'b0;
        out3 = 1'b0;
        busy = 1'b0;
        if (state == PULSE) begin
            busy = 1'b1;
            case (active_code)
                2'b00:   out0 = 1'b1;
                2'b01:   out1 = 1'b1;
                2'b10:   out2 = 1'b1;
                default: out3 = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_2x4_pulse.sv
// tb/tb_decoder_2x4_pulse.sv - randomized bench for decoder_2x4_pulse against an interval-schedule model
module tb_decoder_2x4_pulse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;
    logic [1:0] v;
    logic [1:0] y1;
    logic [1:0] y0;
    logic [1:0] ready;
    logic [1:0] busy;
    logic [3:0] outs_a;
    logic [3:0] outs_b;

    decoder_2x4_pulse #(.PULSE_LEN(4), .CNT_W(8)) u_dut_len4 (
        .clk   (clk),
        .rst_n (rst_n[0]),
        .v     (v[0]),
        .y1    (y1[0]),
        .y0    (y0[0]),
        .ready (ready[0]),
        .out3  (outs_a[3]),
        .out2  (outs_a[2]),
        .out1  (outs_a[1]),
        .out0  (outs_a[0]),
        .busy  (busy[0])
    );

    decoder_2x4_pulse #(.PULSE_LEN(1), .CNT_W(8)) u_dut_len1 (
        .clk   (clk),
        .rst_n (rst_n[1]),
        .v     (v[1]),
        .y1    (y1[1]),
        .y0    (y0[1]),
        .ready (ready[1]),
        .out3  (outs_b[3]),
        .out2  (outs_b[2]),
        .out1  (outs_b[1]),
        .out0  (outs_b[0]),
        .busy  (busy[1])
    );

    int total = 0;
    int bad   = 0;

    // Model: each accepted code becomes a scheduled interval [start, start+pl) of edge indices.
    int sel;
    int pl;
    int cyc = 0;
    int q_start[$];
    int q_code[$];
    int busy_end;
    int pend_l;
    int cur_code;
    bit accepted_last;
    int n_accept;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d sel=%0d cyc=%0d got=%0h want=%0h", tag, sel, sel, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_start.delete();
        q_code.delete();
        busy_end      = 0;
        pend_l        = -1;
        cur_code      = -1;
        accepted_last = 1'b0;
    endtask

    task automatic model_edge();
        bit ready_before;
        int start;
        ready_before  = (cyc >= pend_l);
        cyc++;
        accepted_last = 1'b0;
        if (rst_n[sel] && v[sel] && ready_before) begin
            start = (cyc + 1 > busy_end) ? cyc + 1 : busy_end;
            q_start.push_back(start);
            q_code.push_back({y1[sel], y0[sel]});
            busy_end      = start + pl;
            pend_l        = start;
            accepted_last = 1'b1;
            n_accept++;
        end
        while (q_start.size() > 0 && q_start[0] + pl <= cyc) begin
            void'(q_start.pop_front());
            void'(q_code.pop_front());
        end
        cur_code = (q_start.size() > 0 && q_start[0] <= cyc) ? q_code[0] : -1;
    endtask

    task automatic compare();
        logic [3:0] o;
        logic [3:0] exp_o;
        o     = sel ? outs_b : outs_a;
        exp_o = (cur_code < 0) ? 4'b0000 : 4'(1 << cur_code);
        check_eq("outs", 32'(o), 32'(exp_o));
        check_eq("busy", 32'(busy[sel]), 32'(cur_code >= 0));
        check_eq("ready", 32'(ready[sel]), 32'(cyc >= pend_l));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive_random();
        if (v[sel] && !accepted_last) begin
            return;
        end
        v[sel]  = ($urandom_range(0, 3) != 0);
        y1[sel] = 1'($urandom_range(0, 1));
        y0[sel] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int guard;
        rst_n = 2'b00;
        v     = 2'b00;
        y1    = 2'b00;
        y0    = 2'b00;
        sel   = 0;
        pl    = 4;
        model_reset();

        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            check_eq("reset_outs", 32'(s ? outs_b : outs_a), 32'd0);
            check_eq("reset_busy", 32'(busy[s]), 32'd0);
            check_eq("reset_ready", 32'(ready[s]), 32'd1);
        end
        @(negedge clk);
        rst_n = 2'b11;

        for (int s = 0; s < 2; s++) begin
            sel      = s;
            pl       = s ? 1 : 4;
            n_accept = 0;
            model_reset();
            for (int i = 0; i < 600; i++) begin
                step();
                drive_random();
            end
            v[s] = 1'b0;
            for (int i = 0; i < 12; i++) begin
                step();
            end
            check_eq("accepted_some", 32'(n_accept > 20), 32'd1);
        end

        // Asynchronous reset in the middle of an out2 strobe with 01 pending.
        sel = 0;
        pl  = 4;
        model_reset();
        v[0]  = 1'b1;
        y1[0] = 1'b1;
        y0[0] = 1'b0;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!accepted_last && guard < 20);
        check_eq("accept_10_timeout", 32'(accepted_last), 32'd1);
        y1[0] = 1'b0;
        y0[0] = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!accepted_last && guard < 20);
        check_eq("accept_01_timeout", 32'(accepted_last), 32'd1);
        v[0] = 1'b0;
        check_eq("pre_reset_out2", 32'(outs_a), 32'd4);
        check_eq("pre_reset_ready", 32'(ready[0]), 32'd0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check_eq("async_outs", 32'(outs_a), 32'd0);
        check_eq("async_busy", 32'(busy[0]), 32'd0);
        check_eq("async_ready", 32'(ready[0]), 32'd1);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
        end
        rst_n[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_2x4_pulse.md
# decoder_2x4_pulse

Registered 2-to-4 decoder and strobe generator: the receiving end of the 4-to-2 priority-encoder link. It accepts an encoded code (`y1`,`y0`) qualified by `v`, buffers one pending code, and drives the matching one-hot output line high for a programmable number of cycles. It sits downstream of the encoder stage and turns encoded requests back into timed one-hot strobes for line-level consumers.

## Interface
- `PULSE_LEN`, default 4: cycles each decoded line is held high; legal range 1..255.
- `CNT_W`, default 8: pulse counter width; must satisfy 2^CNT_W > PULSE_LEN-1.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `v`  input  1  input code valid.
- `y1`  input  1  code bit 1 (MSB).
- `y0`  input  1  code bit 0 (LSB).
- `ready`  output  1  block can accept a code this cycle.
- `out3`..`out0`  output  1 each  one-hot decoded strobes; `outN` high means code N is being pulsed.
- `busy`  output  1  a strobe is currently active.

## Operation
- State: 1-entry pending buffer (`pend_valid`, `pend_code[1:0]`), active code register, down-counter `cnt[CNT_W-1:0]`, FSM {IDLE, PULSE}.
- Handshake: transfer occurs on an edge where `v && ready`. `ready = !pend_valid` (combinational from the register only, never from `v`). When `v` is high and `ready` is low, the code is not taken; the source holds `v`/code until a transfer.
- Transfer: `pend_code <= {y1,y0}`, `pend_valid <= 1`.
- IDLE: all `outN` = 0, `busy` = 0. If `pend_valid`: load active code from `pend_code`, `cnt <= PULSE_LEN-1`, clear `pend_valid`, go to PULSE.
- PULSE: `out[active]` = 1 and other lines 0; `busy` = 1.
  - `cnt != 0`: `cnt <= cnt-1`.
  - `cnt == 0` and `pend_valid`: load the next code, reload `cnt <= PULSE_LEN-1`, clear `pend_valid`, stay in PULSE (back-to-back, no gap cycle).
  - `cnt == 0` and `!pend_valid`: go to IDLE.
- Outputs are registered (decoded from the active register and state); exactly zero or one `outN` is high in any cycle.
- Codes map directly: 00 → `out0`, 01 → `out1`, 10 → `out2`, 11 → `out3`. A zero code from an all-zero encoder input arrives with `v`=0 and is ignored.

## Timing
- Reset (`rst_n` low, any time, asynchronous): FSM = IDLE, `pend_valid` = 0, `cnt` = 0, active code = 0. Outputs during and after reset: `out3..out0` = 0, `busy` = 0, `ready` = 1. Reset mid-pulse drops the strobe immediately and discards any pending code.
- Latency: transfer at edge E → pending at E → load at E+1 → `outN` high from E+1 through edge E+1+PULSE_LEN, i.e. exactly `PULSE_LEN` cycles.
- `ready` is low for the cycle after a transfer whenever the pending entry is not consumed on the next edge. In IDLE this is one cycle. During PULSE it lasts until the `cnt==0` edge.
- No same-edge accept-and-consume conflict can occur, because `ready` = 0 whenever `pend_valid` = 1.
- Sustained throughput with `v` held high: one code per `PULSE_LEN` cycles with strobes contiguous. With PULSE_LEN=1 this is one code every 2 cycles, because the pending entry blocks `ready`.
- `busy` equals OR of `out3..out0`.

## Test plan
- Reset: assert `rst_n`=0 mid-pulse (`out2` high) → `out3..0`=0000, `busy`=0 and `ready`=1 asynchronously. The pending code is lost, and nothing pulses after release.
- Single code, PULSE_LEN=4: `v`=1, code 10 for one cycle at edge E → `ready` low for 1 cycle; `out2` high for exactly 4 cycles starting after E+1; other lines stay 0. `busy` tracks `out2`.
- All codes: send 00, 01, 10, 11 separated by idle gaps → `out0`, `out1`, `out2`, `out3` pulse 4 cycles each, in order, never overlapping.
- Back-to-back: hold `v`=1 presenting 11 then 01 (advance code on each transfer) → `out3` for 4 cycles, then `out1` for 4 cycles with no gap. `ready` returns to 1 on the edge 01 is loaded.
- Backpressure: during an `out0` pulse, transfer 10, then keep `v`=1 with code 01 → 01 is not accepted until the 10 strobe is loaded. Code 01 is never dropped or duplicated.
- PULSE_LEN=1 build: stream 00,11,10 with `v` held → each line high exactly 1 cycle; throughput one code per 2 cycles.
